contador_mod_n: RTL and testbench
=================================

# contador_mod_n

Parametrised synchronous modulo-N counter with programmable terminal value, up/down direction, three terminal behaviours (wrap, saturate, one-shot), parallel load and a registered terminal-count pulse. It is the general-purpose sequencing counter for the ULA datapath and control path, used for operation-step counters, delay timers and iteration counters. It replaces fixed-width, fixed-modulus counters.

## Interface
- WIDTH, 4: counter width in bits; legal range ≥ 2.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear: count to 0, done to 0.
- load  input  1  synchronous parallel load of load_value.
- load_value  input  WIDTH  value for load.
- enable  input  1  take one count step this cycle.
- up_down  input  1  1 = count up, 0 = count down.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap.
- limit  input  WIDTH  terminal value; modulus = limit + 1; sampled every cycle.
- count  output  WIDTH  registered counter value.
- at_term  output  1  combinational: count at terminal for current direction.
- tc_pulse  output  1  registered one-cycle terminal-count pulse.
- done  output  1  registered sticky flag; one-shot completion.

## Operation
- Priority per edge: rst > clear > load > enable step > hold.
- rst: count = 0, tc_pulse = 0, done = 0.
- clear: count = 0, done = 0, tc_pulse = 0.
- load: count = load_value if load_value ≤ limit, else limit. done = 0, tc_pulse = 0.
- Terminal: up → count ≥ limit; down → count == 0. at_term = terminal condition (includes count > limit when up).
- Step up, not terminal: count + 1.
- Step up, terminal: wrap → 0; saturate → hold; one-shot → hold, done = 1.
- Step down, count > limit: count = limit, no pulse.
- Step down, not terminal: count − 1.
- Step down, terminal: wrap → limit; saturate → hold 0; one-shot → hold, done = 1.
- tc_pulse = 1 in the cycle after any enabled step taken at terminal. Exception: one-shot with done already 1.
- While done = 1: enable ignored, count held; only rst/clear/load exit.
- Changing mode or up_down mid-count: takes effect on the next step, no state flush.
- limit = 0: up or down at 0 is always terminal; wrap holds 0 and pulses every enabled cycle.
- Arithmetic is modulo 2^WIDTH internally; no carry output. limit = 2^WIDTH − 1 gives a full-range counter.

## Timing
- count, done, tc_pulse: 1-cycle latency from the controlling inputs at the edge.
- at_term: zero-latency, from count, limit and up_down.
- tc_pulse high exactly one cycle per terminal step; consecutive enabled terminal steps in saturate mode give a continuous high.
- rst, clear or load in the same cycle as a terminal step suppresses that tc_pulse.
- Reset mid-operation: outputs are 0 on the first edge with rst = 1. Counting resumes on the first edge after rst falls, if enable is high.

## Structure
- Shared package/header for the whole design holds:
  - mode encodings: MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - direction constants: DIR_UP, DIR_DOWN.
- Sub-module: dff_sync_rst, a WIDTH-parametrised D register with synchronous active-high reset and enable. It is instantiated for count; single-bit instances are used for done and tc_pulse.
- Next-value logic (step, compare, clamp) stays in contador_mod_n, built from gate primitives and generate loops.

## Test plan
- WIDTH = 4, limit = 5, up, wrap, enable held: count 0,1,2,3,4,5,0,1. tc_pulse = 1 only in the cycle count returns to 0. at_term = 1 while count = 5.
- limit = 5, down, wrap, starting from 0: count 0,5,4,3,2,1,0,5. tc_pulse follows each 0→5 step.
- limit = 3, up, saturate: count 0,1,2,3,3,3. tc_pulse low on the 2→3 step, high on each step taken at 3.
- limit = 2, up, one-shot: count 0,1,2,2. done = 1 and single tc_pulse after the step at 2. Further enables are ignored. clear returns count = 0, done = 0.
- load_value = 9 with limit = 6: count = 6 after load. Then limit = 4 with down step: count = 4. load and enable together: the load wins.
- rst asserted while count = 3 with enable high: count = 0 on that edge. Deassert: 1 on the next edge. rst with clear and load together: rst result.

Source files
------------

// File: rtl/contador_mod_n_pkg.sv
// Shared encodings for the modulo-N sequencing counter: terminal-behaviour modes
// and count-direction constants.
package contador_mod_n_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/contador_mod_n_if.sv
// Control/status bundle of the modulo-N counter; master drives the controls,
// slave is the counter itself.
interface contador_mod_n_if
  import contador_mod_n_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  mode_e            mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             at_term;
  logic             tc_pulse;
  logic             done;

  modport master (
    output clear, load, load_value, enable, up_down, mode, limit,
    input  count, at_term, tc_pulse, done
  );

  modport slave (
    input  clear, load, load_value, enable, up_down, mode, limit,
    output count, at_term, tc_pulse, done
  );

endinterface

// File: rtl/contador_mod_n_dff_sync_rst.sv
// Parametrised D register with synchronous active-high reset and load enable.
module dff_sync_rst #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/contador_mod_n.sv
// Modulo-N up/down counter with programmable limit, wrap/saturate/one-shot
// terminal behaviour, clamped parallel load and a registered terminal pulse.
module contador_mod_n
  import contador_mod_n_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  contador_mod_n_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] incVal, decVal, incCarry, decBorrow, cntEqBits;
  logic [WIDTH:0]   cntBorrow, ldBorrow;
  logic             cntGtLim, cntEqLim, cntIsZero, ldGtLim, atTerm, countEn;
  logic [WIDTH-1:0] ldVal;

  assign incCarry[0]  = 1'b1;
  assign decBorrow[0] = 1'b1;
  assign cntBorrow[0] = 1'b0;
  assign ldBorrow[0]  = 1'b0;

  // Ripple incrementer/decrementer, and "a > limit" as the borrow out of limit - a.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic nLim, cG, cP, cPa, lEq, lG, lPa;
    not  (nLim, bus.limit[i]);
    and  (cG, nLim, count_q[i]);
    xnor (cntEqBits[i], bus.limit[i], count_q[i]);
    and  (cPa, cntEqBits[i], cntBorrow[i]);
    or   (cntBorrow[i+1], cG, cPa);
    and  (lG, nLim, bus.load_value[i]);
    xnor (lEq, bus.limit[i], bus.load_value[i]);
    and  (lPa, lEq, ldBorrow[i]);
    or   (ldBorrow[i+1], lG, lPa);
    xor  (incVal[i], count_q[i], incCarry[i]);
    xor  (decVal[i], count_q[i], decBorrow[i]);
    not  (cP, count_q[i]);
    if (i < WIDTH - 1) begin : g_chain
      and (incCarry[i+1], count_q[i], incCarry[i]);
      and (decBorrow[i+1], cP, decBorrow[i]);
    end
  end

  assign cntGtLim  = cntBorrow[WIDTH];
  assign ldGtLim   = ldBorrow[WIDTH];
  assign cntEqLim  = &cntEqBits;
  assign cntIsZero = ~|count_q;
  assign atTerm    = (bus.up_down == DIR_UP) ? (cntGtLim | cntEqLim) : cntIsZero;
  assign ldVal     = ldGtLim ? bus.limit : bus.load_value;
  assign countEn   = bus.clear | bus.load | (bus.enable & ~done_q);

  // Next-state selection; a completed one-shot ignores enable until clear/load/rst.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = ldVal;
      done_d  = 1'b0;
    end else if (bus.enable && !done_q) begin
      if (bus.up_down == DIR_UP) begin
        if (!atTerm) begin
          count_d = incVal;
        end else begin
          tc_d = 1'b1;
          case (bus.mode)
            MODE_SAT:     count_d = count_q;
            MODE_ONESHOT: done_d  = 1'b1;
            default:      count_d = '0;
          endcase
        end
      end else if (cntGtLim) begin
        count_d = bus.limit;
      end else if (!cntIsZero) begin
        count_d = decVal;
      end else begin
        tc_d = 1'b1;
        case (bus.mode)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: done_d  = 1'b1;
          default:      count_d = bus.limit;
        endcase
      end
    end
  end

  dff_sync_rst #(.WIDTH(WIDTH)) uCount (
    .clk (clk), .rst (rst), .en_i (countEn), .d_i (count_d), .q_o (count_q)
  );

  dff_sync_rst #(.WIDTH(1)) uDone (
    .clk (clk), .rst (rst), .en_i (1'b1), .d_i (done_d), .q_o (done_q)
  );

  dff_sync_rst #(.WIDTH(1)) uTc (
    .clk (clk), .rst (rst), .en_i (1'b1), .d_i (tc_d), .q_o (tc_q)
  );

  assign bus.count    = count_q;
  assign bus.at_term  = atTerm;
  assign bus.tc_pulse = tc_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_contador_mod_n.sv
// Bench for contador_mod_n: directed vector table for the documented scenarios,
// then randomized traffic compared against an integer reference model.
module tb_contador_mod_n;
  import contador_mod_n_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  contador_mod_n_if #(.WIDTH(W)) bus ();

  contador_mod_n #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit rst; bit clr; bit ld; int lv; bit en; bit ud; int md; int lim;
    int expCount; bit expTc; bit expDone; bit expAt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   mCount = 0;
  int   mDone  = 0;
  int   mTc    = 0;

  function automatic void addVec(input bit r, input bit c, input bit l, input int lv,
                                 input bit e, input bit u, input int md, input int lim,
                                 input int ec, input bit et, input bit ed, input bit ea);
    vec_t v;
    v = '{r, c, l, lv, e, u, md, lim, ec, et, ed, ea};
    vecs.push_back(v);
  endfunction

  // Reference behaviour from the counting rules, on plain integers.
  function automatic void modelStep(input bit r, input bit c, input bit l, input int lv,
                                    input bit e, input bit u, input int md, input int lim);
    int nc, nd, nt;
    nc = mCount; nd = mDone; nt = 0;
    if (r || c) begin
      nc = 0; nd = 0;
    end else if (l) begin
      nc = (lv > lim) ? lim : lv; nd = 0;
    end else if (e && mDone == 0) begin
      if (u) begin
        if (mCount < lim) nc = mCount + 1;
        else begin
          nt = 1;
          if (md == 2) nd = 1;
          else if (md != 1) nc = 0;
        end
      end else begin
        if (mCount > lim) nc = lim;
        else if (mCount > 0) nc = mCount - 1;
        else begin
          nt = 1;
          if (md == 2) nd = 1;
          else if (md != 1) nc = lim;
        end
      end
    end
    mCount = nc; mDone = nd; mTc = nt;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit l, input int lv,
                               input bit e, input bit u, input int md, input int lim);
    @(negedge clk);
    rst            = r;
    bus.clear      = c;
    bus.load       = l;
    bus.load_value = lv[W-1:0];
    bus.enable     = e;
    bus.up_down    = u;
    bus.mode       = mode_e'(md[1:0]);
    bus.limit      = lim[W-1:0];
    @(posedge clk);
    modelStep(r, c, l, lv, e, u, md, lim);
    #1;
  endtask

  initial begin
    int curLim, curUd, curMd, lv;
    bit r, c, l, e;

    // wrap up, limit 5
    addVec(1,0,0,0,0,1,0,5, 0,0,0,0);
    addVec(0,0,0,0,1,1,0,5, 1,0,0,0);
    addVec(0,0,0,0,1,1,0,5, 2,0,0,0);
    addVec(0,0,0,0,1,1,0,5, 3,0,0,0);
    addVec(0,0,0,0,1,1,0,5, 4,0,0,0);
    addVec(0,0,0,0,1,1,0,5, 5,0,0,1);
    addVec(0,0,0,0,1,1,0,5, 0,1,0,0);
    addVec(0,0,0,0,1,1,0,5, 1,0,0,0);
    // wrap down, limit 5
    addVec(0,1,0,0,0,0,0,5, 0,0,0,1);
    addVec(0,0,0,0,1,0,0,5, 5,1,0,0);
    addVec(0,0,0,0,1,0,0,5, 4,0,0,0);
    addVec(0,0,0,0,1,0,0,5, 3,0,0,0);
    addVec(0,0,0,0,1,0,0,5, 2,0,0,0);
    addVec(0,0,0,0,1,0,0,5, 1,0,0,0);
    addVec(0,0,0,0,1,0,0,5, 0,0,0,1);
    addVec(0,0,0,0,1,0,0,5, 5,1,0,0);
    // saturate up, limit 3
    addVec(0,1,0,0,0,1,1,3, 0,0,0,0);
    addVec(0,0,0,0,1,1,1,3, 1,0,0,0);
    addVec(0,0,0,0,1,1,1,3, 2,0,0,0);
    addVec(0,0,0,0,1,1,1,3, 3,0,0,1);
    addVec(0,0,0,0,1,1,1,3, 3,1,0,1);
    addVec(0,0,0,0,1,1,1,3, 3,1,0,1);
    // one-shot up, limit 2
    addVec(0,1,0,0,0,1,2,2, 0,0,0,0);
    addVec(0,0,0,0,1,1,2,2, 1,0,0,0);
    addVec(0,0,0,0,1,1,2,2, 2,0,0,1);
    addVec(0,0,0,0,1,1,2,2, 2,1,1,1);
    addVec(0,0,0,0,1,1,2,2, 2,0,1,1);
    addVec(0,0,0,0,1,1,2,2, 2,0,1,1);
    addVec(0,1,0,0,1,1,2,2, 0,0,0,0);
    // clamped load, limit shrink on down step, load beats enable
    addVec(0,0,1,9,0,1,0,6, 6,0,0,1);
    addVec(0,0,0,0,1,0,0,4, 4,0,0,0);
    addVec(0,0,1,2,1,1,0,4, 2,0,0,0);
    // reset mid-count, then combined rst/clear/load
    addVec(0,0,0,0,1,1,0,4, 3,0,0,0);
    addVec(1,0,0,0,1,1,0,4, 0,0,0,0);
    addVec(0,0,0,0,1,1,0,4, 1,0,0,0);
    addVec(1,1,1,3,1,1,0,4, 0,0,0,0);
    // limit 0: every enabled step is terminal
    addVec(0,1,0,0,0,1,0,0, 0,0,0,1);
    addVec(0,0,0,0,1,1,0,0, 0,1,0,1);
    addVec(0,0,0,0,1,1,0,0, 0,1,0,1);
    addVec(0,1,0,0,1,1,0,0, 0,0,0,1);
    addVec(0,0,0,0,1,0,1,0, 0,1,0,1);
    addVec(0,0,0,0,1,1,2,0, 0,1,1,1);
    addVec(0,0,0,0,1,1,2,0, 0,0,1,1);
    // full-range wrap
    addVec(0,0,1,15,0,1,0,15, 15,0,0,1);
    addVec(0,0,0,0,1,1,0,15, 0,1,0,0);

    $display("[TB] directed table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].lv,
                    vecs[i].en, vecs[i].ud, vecs[i].md, vecs[i].lim);
      checkOutput($sformatf("vec%0d count", i), int'(bus.count), vecs[i].expCount);
      checkOutput($sformatf("vec%0d tc_pulse", i), int'(bus.tc_pulse), int'(vecs[i].expTc));
      checkOutput($sformatf("vec%0d done", i), int'(bus.done), int'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d at_term", i), int'(bus.at_term), int'(vecs[i].expAt));
    end

    $display("[TB] randomized phase");
    curLim = 5; curUd = 1; curMd = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       curLim = 0;
          1:       curLim = 15;
          default: curLim = $urandom_range(0, 15);
        endcase
      end
      if ($urandom_range(0, 9) == 0) curUd = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) curMd = $urandom_range(0, 3);
      r  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 11) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = $urandom_range(0, 15);
      applyStimulus(r, c, l, lv, e, curUd[0], curMd, curLim);
      checkOutput("rand count", int'(bus.count), mCount);
      checkOutput("rand tc_pulse", int'(bus.tc_pulse), mTc);
      checkOutput("rand done", int'(bus.done), mDone);
      checkOutput("rand at_term", int'(bus.at_term),
                  (curUd != 0) ? int'(mCount >= curLim) : int'(mCount == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
